// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch unit.
// Owns the architectural PC and keeps at most one instruction-memory request
// in flight. It holds the fetched word for decode until the core retires it.
// On retire it forms the next PC from the control unit's PC-select.
// A target with address bit 1 set parks the unit in a sticky fault state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    output logic        misaligned_fault
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } fetchStateT;

    localparam logic [1:0] SEL_PC4  = 2'b00;
    localparam logic [1:0] SEL_PCIM = 2'b01;
    localparam logic [1:0] SEL_RS1  = 2'b10;

    fetchStateT  stateReg, stateNext;
    logic [31:0] pcReg, pcNext;
    logic [31:0] instReg, instNext;
    logic [31:0] instPcReg, instPcNext;
    logic        instValidReg, instValidNext;
    logic        faultReg, faultNext;
    logic [31:0] targetPc;

    // Candidate next PC. Only consumed in the retire cycle, so it may be
    // computed unconditionally. The reserved select falls back to PC+4.
    always_comb begin
        targetPc = pcReg + 32'd4;
        case (pc_sel)
            SEL_PC4:  targetPc = pcReg + 32'd4;
            SEL_PCIM: targetPc = pcReg + imm;
            SEL_RS1:  targetPc = (rs1_val + imm) & ~32'h1;
            default:  targetPc = pcReg + 32'd4;
        endcase
    end

    // Next-state and datapath update for the fetch sequence REQ -> WAIT -> HOLD.
    always_comb begin
        stateNext     = stateReg;
        pcNext        = pcReg;
        instNext      = instReg;
        instPcNext    = instPcReg;
        instValidNext = instValidReg;
        faultNext     = faultReg;
        case (stateReg)
            S_REQ: begin
                if (imem_req_ready) begin
                    stateNext = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    instNext      = imem_resp_data;
                    instPcNext    = pcReg;
                    instValidNext = 1'b1;
                    stateNext     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    pcNext        = targetPc;
                    instValidNext = 1'b0;
                    instNext      = NOP_INST;
                    if (targetPc[1]) begin
                        faultNext = 1'b1;
                        stateNext = S_FAULT;
                    end else begin
                        stateNext = S_REQ;
                    end
                end
            end
            S_FAULT: begin
                // Parked until reset; pc keeps the faulting target.
                stateNext = S_FAULT;
            end
            default: begin
                stateNext = S_REQ;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg     <= S_REQ;
            pcReg        <= RESET_PC;
            instReg      <= NOP_INST;
            instPcReg    <= 32'h0;
            instValidReg <= 1'b0;
            faultReg     <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            pcReg        <= pcNext;
            instReg      <= instNext;
            instPcReg    <= instPcNext;
            instValidReg <= instValidNext;
            faultReg     <= faultNext;
        end
    end

    // Request is only offered in S_REQ and is suppressed while reset is held.
    always_comb begin
        imem_req_valid   = (stateReg == S_REQ) && !rst;
        imem_req_addr    = pcReg;
        inst_valid       = instValidReg;
        inst             = instReg;
        inst_pc          = instPcReg;
        misaligned_fault = faultReg;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// It runs directed scenarios and then randomized traffic. All results are
// checked against a transaction-level model of PC, held instruction and fault.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [31:0] imm = 32'h0;
    logic [31:0] rs1_val = 32'h0;
    logic        misaligned_fault;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .inst_valid       (inst_valid),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .inst_ready       (inst_ready),
        .pc_sel           (pc_sel),
        .imm              (imm),
        .rs1_val          (rs1_val),
        .misaligned_fault (misaligned_fault)
    );

    // Reference model: architectural PC, the held instruction (if any),
    // whether a request is outstanding, and the sticky fault flag.
    logic [31:0] mPc;
    logic [31:0] mInst;
    logic [31:0] mInstPc;
    bit          mHave;
    bit          mOut;
    bit          mFault;

    int compared   = 0;
    int mismatched = 0;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] nextPc(input logic [31:0] pc, input logic [1:0] sel,
                                           input logic [31:0] im, input logic [31:0] r1);
        if (sel == 2'd1) return pc + im;
        if (sel == 2'd2) return (r1 + im) & 32'hFFFF_FFFE;
        return pc + 32'd4;
    endfunction

    task automatic checkOutputs(input string tag);
        checkValue({tag, ".req_valid"}, 32'(imem_req_valid), 32'(!mFault && !mOut && !mHave));
        checkValue({tag, ".req_addr"},  imem_req_addr, mPc);
        checkValue({tag, ".inst_valid"}, 32'(inst_valid), 32'(mHave));
        checkValue({tag, ".inst"},       inst, mHave ? mInst : NOP);
        checkValue({tag, ".inst_pc"},    inst_pc, mInstPc);
        checkValue({tag, ".fault"},      32'(misaligned_fault), 32'(mFault));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, check.
    task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rd, input bit ir,
                         input logic [1:0] sel, input logic [31:0] im, input logic [31:0] r1,
                         input string tag);
        bit reqOffered;
        logic [31:0] nxt;
        imem_req_ready  = rdy;
        imem_resp_valid = rv;
        imem_resp_data  = rd;
        inst_ready      = ir;
        pc_sel          = sel;
        imm             = im;
        rs1_val         = r1;
        reqOffered = !mFault && !mOut && !mHave;
        @(posedge clk);
        if (mHave && ir) begin
            nxt   = nextPc(mInstPc, sel, im, r1);
            $display("retire  pc=%h inst=%h sel=%0d next=%h", mInstPc, mInst, sel, nxt);
            mHave = 0;
            mPc   = nxt;
            if (nxt[1]) mFault = 1;
        end else if (mOut && rv) begin
            mOut    = 0;
            mHave   = 1;
            mInst   = rd;
            mInstPc = mPc;
        end else if (reqOffered && rdy) begin
            mOut = 1;
            $display("request addr=%h", mPc);
        end
        @(negedge clk);
        checkOutputs(tag);
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        mPc = 32'h0; mHave = 0; mOut = 0; mFault = 0; mInstPc = 32'h0; mInst = NOP;
        checkValue({tag, ".rst_req_valid"}, 32'(imem_req_valid), 32'h0);
        checkValue({tag, ".rst_fault"},     32'(misaligned_fault), 32'h0);
        checkValue({tag, ".rst_inst_valid"}, 32'(inst_valid), 32'h0);
        checkValue({tag, ".rst_inst"},      inst, NOP);
        checkValue({tag, ".rst_inst_pc"},   inst_pc, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutputs({tag, ".release"});
        $display("reset   pc=%h", mPc);
    endtask

    // Fetch from the current PC with zero wait and retire with the given select.
    task automatic fetchRetire(input logic [1:0] sel, input logic [31:0] im,
                               input logic [31:0] r1, input string tag);
        logic [31:0] word;
        word = $urandom;
        cycle(1, 0, 32'h0, 0, 2'd0, 32'h0, 32'h0, {tag, ".req"});
        cycle(0, 1, word, 0, 2'd0, 32'h0, 32'h0, {tag, ".resp"});
        cycle(0, 0, 32'h0, 1, sel, im, r1, {tag, ".retire"});
    endtask

    initial begin
        int faultCycles;
        bit rdy, rv, ir;
        logic [31:0] rd, im, r1, junk;
        logic [1:0] sel;
        int k;

        doReset("init");

        // First fetch from reset: request at 0, instruction visible 2 cycles later.
        cycle(1, 0, 32'h0, 0, 2'd0, 32'h0, 32'h0, "first.req");
        cycle(0, 1, 32'h0050_0093, 0, 2'd0, 32'h0, 32'h0, "first.resp");
        checkValue("first.inst_exact", inst, 32'h0050_0093);
        cycle(0, 0, 32'h0, 1, 2'd0, 32'h0, 32'h0, "first.retire");

        // Request held for 3 cycles of no-ready at pc=4, then retire to 8.
        repeat (3) cycle(0, 0, 32'h0, 0, 2'd0, 32'h0, 32'h0, "stall.req");
        checkValue("stall.addr_exact", imem_req_addr, 32'h4);
        fetchRetire(2'd0, 32'h0, 32'h0, "seq");
        checkValue("seq.addr8", imem_req_addr, 32'h8);

        // Jump to 0x100, branch back by 16, then jump forward by 0x20.
        fetchRetire(2'd1, 32'h0000_00F8, 32'h0, "to100");
        fetchRetire(2'd1, 32'hFFFF_FFF0, 32'h0, "branch");
        checkValue("branch.addrF0", imem_req_addr, 32'hF0);
        fetchRetire(2'd1, 32'h0000_0010, 32'h0, "back100");
        fetchRetire(2'd1, 32'h0000_0020, 32'h0, "jal");
        checkValue("jal.addr120", imem_req_addr, 32'h120);

        // JALR with odd base: bit 0 cleared, no fault.
        fetchRetire(2'd2, 32'h0000_0004, 32'h0000_2001, "jalr");
        checkValue("jalr.addr2004", imem_req_addr, 32'h2004);
        checkValue("jalr.nofault", 32'(misaligned_fault), 32'h0);

        // Reserved select behaves as PC+4; wrap from the top of the address space.
        fetchRetire(2'd3, 32'h1234_5678, 32'h0, "reserved");
        fetchRetire(2'd2, 32'hFFFF_FFFC, 32'h0, "totop");
        fetchRetire(2'd0, 32'h0, 32'h0, "wrap");
        checkValue("wrap.addr0", imem_req_addr, 32'h0);

        // Backpressure: instruction held 10 cycles with no new request.
        cycle(1, 0, 32'h0, 0, 2'd0, 32'h0, 32'h0, "bp.req");
        cycle(0, 1, 32'hCAFE_0013, 0, 2'd0, 32'h0, 32'h0, "bp.resp");
        for (int i = 0; i < 10; i++) begin
            junk = $urandom;
            cycle(1, 1, junk, 0, 2'd1, junk, junk, "bp.hold");
        end
        cycle(0, 0, 32'h0, 1, 2'd0, 32'h0, 32'h0, "bp.retire");

        // Misaligned target: sticky fault, no requests until reset.
        doReset("preMis");
        fetchRetire(2'd1, 32'h0000_0006, 32'h0, "mis");
        checkValue("mis.fault", 32'(misaligned_fault), 32'h1);
        checkValue("mis.pc6", imem_req_addr, 32'h6);
        for (int i = 0; i < 5; i++) cycle(1, 1, 32'h0, 1, 2'd0, 32'h0, 32'h0, "mis.park");

        // Reset during an outstanding request; a late response must be ignored.
        doReset("misClear");
        cycle(1, 0, 32'h0, 0, 2'd0, 32'h0, 32'h0, "rw.req");
        doReset("rw");
        cycle(0, 1, 32'hDEAD_BEEF, 0, 2'd0, 32'h0, 32'h0, "rw.stale");
        checkValue("rw.stale_valid", 32'(inst_valid), 32'h0);
        fetchRetire(2'd0, 32'h0, 32'h0, "rw.restart");

        // Randomized traffic.
        faultCycles = 0;
        for (int i = 0; i < 1500; i++) begin
            rdy = ($urandom % 4) != 0;
            rv  = ($urandom % 3) != 0;
            rd  = $urandom;
            ir  = ($urandom % 3) != 0;
            sel = 2'($urandom % 4);
            if ($urandom % 8 == 0) begin
                im = $urandom & 32'hFFFF_FFFE;
            end else begin
                k  = int'($urandom_range(0, 64));
                im = 32'((k - 32) * 4);
            end
            r1 = ($urandom % 4 == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            cycle(rdy, rv, rd, ir, sel, im, r1, "rand");
            if (mFault) faultCycles++;
            if (faultCycles > 4 || ($urandom % 300) == 0) begin
                doReset("rand");
                faultCycles = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
